// File: rtl/tick_scheduler_if.sv
// Configuration/sync handshake bundle for tick_scheduler.
// The master side issues channel writes and sync requests; the scheduler answers with cfg_ready.
interface tick_scheduler_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_div;
  logic             sync_req;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_div, sync_req,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_div, sync_req,
    output cfg_ready
  );
endinterface

// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler base tick feeding CH programmable tick/square channels.
// Define TICK_SCHED_PAUSE_EN to add a 'pause' input that freezes the prescaler.
module tick_scheduler #(
  parameter int BASE_DIV = 50000,
  parameter int CH       = 4,
  parameter int DIV_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TICK_SCHED_PAUSE_EN
  input  logic                pause,
`endif
  tick_scheduler_if.slave     cfg,
  output logic                base_tick,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       square
);

  localparam int              BC_W     = $clog2(BASE_DIV);
  localparam logic [BC_W-1:0] BASE_MAX = BC_W'(BASE_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BASE, ALIGN} state_t;

  state_t                   state_q, state_d;
  logic [BC_W-1:0]          base_cnt_q, base_cnt_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic [CH-1:0]            en_q, en_d;
  logic [CH-1:0]            tick_q, tick_d;
  logic [CH-1:0]            square_q, square_d;
  logic [CH-1:0][DIV_W-1:0] div_q, div_d;
  logic [CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic                     paused;
  logic                     base_hit;
  logic                     cfg_wr;

`ifdef TICK_SCHED_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign base_hit = (base_cnt_q == BASE_MAX) && !paused;
  assign cfg_wr   = cfg.cfg_valid && cfg_ready_q;

  always_comb begin
    base_cnt_d = base_cnt_q;
    if (!paused) begin
      base_cnt_d = (base_cnt_q == BASE_MAX) ? '0 : base_cnt_q + 1'b1;
    end
  end

  // cfg_ready is registered from the next state so it stays low while reset is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cfg.sync_req && cfg_ready_q) state_d = WAIT_BASE;
      WAIT_BASE: if (base_hit) state_d = ALIGN;
      ALIGN:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    cfg_ready_d = (state_d == IDLE);
  end

  always_comb begin
    en_d     = en_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = '0;
    square_d = square_q;
    for (int i = 0; i < CH; i++) begin
      if (state_q == ALIGN) begin
        cnt_d[i]    = div_q[i];
        square_d[i] = 1'b0;
      end else if (base_hit && en_q[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i]    = div_q[i];
          tick_d[i]   = 1'b1;
          square_d[i] = ~square_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      // A write landing on a base tick suppresses that channel's tick.
      if (cfg_wr && (cfg.cfg_ch == 3'(i))) begin
        en_d[i]     = cfg.cfg_en;
        div_d[i]    = cfg.cfg_div;
        cnt_d[i]    = cfg.cfg_div;
        tick_d[i]   = 1'b0;
        square_d[i] = square_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      en_q        <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      tick_q      <= '0;
      square_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_cnt_q  <= base_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      en_q        <= en_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      square_q    <= square_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign base_tick     = base_hit;
  assign tick          = tick_q;
  assign square        = square_q;

endmodule
